mesi_bus_arbiter: RTL and testbench

Snoop-bus controller for the N-cache MESI system. It arbitrates bus requests from the caches round-robin and broadcasts the winning transaction as a snoop to all other caches. It then collects their hit/dirty responses, sequences the write-back and memory-read handshakes, and returns the MESI fill state to the requester. It sits in `top_system` between the per-cache controllers and the shared memory port.

---
 rtl/mesi_bus_arbiter_pkg.sv | 38 +++
 rtl/mesi_bus_arbiter_if.sv | 43 ++++
 rtl/mesi_bus_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mesi_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_bus_arbiter_pkg.sv
// rtl/mesi_bus_arbiter_pkg.sv - shared types for the MESI snoop-bus arbiter
// Contents: cache line states, bus op encoding, arbiter FSM states and
// the fill-state decode used when a transaction completes.
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_t;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_BUSRD   = 2'b01,
        OP_BUSRDX  = 2'b10,
        OP_BUSUPGR = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_SNOOP,
        ARB_WB,
        ARB_MEM_RD,
        ARB_DONE
    } arb_state_t;

    // A plain read lands in S when any other cache had a copy (clean or
    // just written back), otherwise the requester owns it exclusively.
    // Ownership-taking ops always install M.
    function automatic mesi_state_t fill_for(bus_op_t op, logic shared, logic dirty);
        if (op == OP_BUSRD) begin
            return (shared || dirty) ? MESI_S : MESI_E;
        end
        return MESI_M;
    endfunction

endpackage

// File: rtl/mesi_bus_arbiter_if.sv
// rtl/mesi_bus_arbiter_if.sv - snoop-bus bundle between caches, arbiter and memory
// Signals:
//   req/req_op/req_addr  per-cache bus requests (into the arbiter)
//   gnt/done/fill_state  grant, completion pulse and state to install
//   snp_*                snoop broadcast out, snp_hit/snp_dirty responses in
//   mem_*                shared memory port, mem_ack returns completion
// Modports: master = arbiter side, slave = caches + memory side.
interface mesi_bus_if #(
    parameter int N  = 2,
    parameter int AW = 32
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]          req;
    logic [N-1:0][1:0]     req_op;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0]          gnt;
    logic [N-1:0]          done;
    logic [1:0]            fill_state;
    logic                  snp_valid;
    logic [1:0]            snp_op;
    logic [AW-1:0]         snp_addr;
    logic [IW-1:0]         snp_src;
    logic [N-1:0]          snp_hit;
    logic [N-1:0]          snp_dirty;
    logic                  mem_req;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic                  mem_ack;

    modport master (
        input  req, req_op, req_addr, snp_hit, snp_dirty, mem_ack,
        output gnt, done, fill_state, snp_valid, snp_op, snp_addr, snp_src,
               mem_req, mem_we, mem_addr
    );

    modport slave (
        output req, req_op, req_addr, snp_hit, snp_dirty, mem_ack,
        input  gnt, done, fill_state, snp_valid, snp_op, snp_addr, snp_src,
               mem_req, mem_we, mem_addr
    );

endinterface

// File: rtl/mesi_bus_arbiter_rr_arbiter.sv
// rtl/mesi_bus_arbiter_rr_arbiter.sv - combinational round-robin pick
// Ports:
//   eligible    per-cache eligibility vector
//   rr_ptr      index that has first priority
//   winner      one-hot winner (all zero when nothing is eligible)
//   winner_idx  binary index of the winner (0 when nothing is eligible)
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx
);

    logic found;

    // Two ordered scans: first the indices at or above the pointer, then
    // the wrapped-around ones below it. The first hit wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && eligible[j] && (IW'(j) >= rr_ptr)) begin
                found      = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && eligible[j]) begin
                found      = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// rtl/mesi_bus_arbiter.sv - MESI snoop-bus arbiter and transaction sequencer
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mesi_bus_if.master: requests in, grant/snoop/memory/done out
// Flow: IDLE picks a requester round-robin, SNOOP broadcasts and samples
// hit/dirty, WB writes back a dirty line, MEM_RD fetches the line, DONE
// pulses done[src] with the fill state and advances the pointer.
module mesi_bus_arbiter
    import mesi_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mesi_bus_if.master bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  src_q, src_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    bus_op_t        op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           shared_q, shared_d;
    logic           dirty_q, dirty_d;

    logic [N-1:0]   eligible;
    logic [N-1:0]   win_onehot;
    logic [IW-1:0]  win_idx;
    logic           win_valid;
    logic [N-1:0]   src_onehot;
    logic           snoop_shared;
    logic           snoop_dirty;
    logic [IW-1:0]  src_next;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = bus.req[i] && (bus.req_op[i] != 2'b00);
        end
    end

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr_q),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    assign win_valid  = |win_onehot;
    assign src_onehot = {{(N-1){1'b0}}, 1'b1} << src_q;

    // The requester's own snoop response is never counted.
    assign snoop_shared = |(bus.snp_hit   & ~src_onehot);
    assign snoop_dirty  = |(bus.snp_dirty & ~src_onehot);

    assign src_next = (src_q == IW'(N - 1)) ? '0 : src_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            src_q    <= '0;
            rr_ptr_q <= '0;
            op_q     <= OP_NONE;
            addr_q   <= '0;
            shared_q <= 1'b0;
            dirty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            shared_q <= shared_d;
            dirty_q  <= dirty_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        addr_d   = addr_q;
        shared_d = shared_q;
        dirty_d  = dirty_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    src_d   = win_idx;
                    op_d    = bus_op_t'(bus.req_op[win_idx]);
                    addr_d  = bus.req_addr[win_idx];
                    state_d = ARB_SNOOP;
                end
            end
            ARB_SNOOP: begin
                shared_d = snoop_shared;
                dirty_d  = snoop_dirty;
                if (snoop_dirty) begin
                    state_d = ARB_WB;
                end else if (op_q == OP_BUSUPGR) begin
                    state_d = ARB_DONE;
                end else begin
                    state_d = ARB_MEM_RD;
                end
            end
            ARB_WB: begin
                // An upgrade already holds the data; it only needs the
                // stale owner's copy flushed, not a fresh read.
                if (bus.mem_ack) begin
                    state_d = (op_q == OP_BUSUPGR) ? ARB_DONE : ARB_MEM_RD;
                end
            end
            ARB_MEM_RD: begin
                if (bus.mem_ack) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                rr_ptr_d = src_next;
                state_d  = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Every output is decoded from registered state so nothing reaches the
    // bus combinationally from the request inputs.
    always_comb begin
        bus.gnt        = '0;
        bus.done       = '0;
        bus.fill_state = 2'b00;
        bus.snp_valid  = 1'b0;
        bus.snp_op     = 2'b00;
        bus.snp_addr   = '0;
        bus.snp_src    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        if (state_q != ARB_IDLE) begin
            bus.gnt = src_onehot;
        end
        case (state_q)
            ARB_SNOOP: begin
                bus.snp_valid = 1'b1;
                bus.snp_op    = op_q;
                bus.snp_addr  = addr_q;
                bus.snp_src   = src_q;
            end
            ARB_WB: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = addr_q;
            end
            ARB_MEM_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
            end
            ARB_DONE: begin
                bus.done       = src_onehot;
                bus.fill_state = fill_for(op_q, shared_q, dirty_q);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// tb/tb_mesi_bus_arbiter.sv - scoreboard bench for mesi_bus_arbiter
module tb_mesi_bus_arbiter;
    import mesi_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesi_bus_if #(.N(N), .AW(AW)) bus();

    mesi_bus_arbiter #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int src; logic [1:0] op; logic [AW-1:0] addr; } snp_exp_t;
    typedef struct { logic we; logic [AW-1:0] addr; } mem_exp_t;
    typedef struct { int src; logic [1:0] fill; int lat; } done_exp_t;

    snp_exp_t  snp_q[$];
    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int done_cnt = 0;
    int mem_lat  = 0;
    int wcnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents one.
    always @(negedge clk) begin
        if (bus.gnt != '0) begin
            check("gnt_onehot", 64'($countones(bus.gnt)), 64'd1);
        end
        if (bus.snp_valid) begin
            if (snp_q.size() == 0) begin
                fail_now("snp_unexpected");
            end else begin
                snp_exp_t e;
                e = snp_q.pop_front();
                check("snp_src",  64'(bus.snp_src), 64'(e.src));
                check("snp_op",   64'(bus.snp_op),  64'(e.op));
                check("snp_addr", 64'(bus.snp_addr), 64'(e.addr));
                check("snp_gnt",  64'(bus.gnt), 64'(1 << e.src));
            end
        end
        if (bus.done != '0) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                fail_now("done_unexpected");
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                check("done_vec",   64'(bus.done), 64'(1 << d.src));
                check("fill_state", 64'(bus.fill_state), 64'(d.fill));
                if (d.lat >= 0) begin
                    check("done_cycle", 64'(cyc - t0), 64'(d.lat));
                end
            end
        end
    end

    // Memory model: checks each new request against the queue, acks after mem_lat waits.
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
            if (wcnt == 0) begin
                if (mem_q.size() == 0) begin
                    fail_now("mem_unexpected");
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_we",   64'(bus.mem_we), 64'(m.we));
                    check("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
                end
            end
            if (wcnt >= mem_lat) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},  64'(bus.gnt), 64'd0);
        check({tag, "_done"}, 64'({bus.done, bus.fill_state}), 64'd0);
        check({tag, "_snp"},  64'({bus.snp_valid, bus.snp_op, bus.snp_src}), 64'd0);
        check({tag, "_snp_addr"}, 64'(bus.snp_addr), 64'd0);
        check({tag, "_mem"},  64'({bus.mem_req, bus.mem_we}), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) begin
            fail_now("done_timeout");
        end
        #1;
    endtask

    task automatic drop_requests();
        bus.req      = '0;
        bus.req_op   = '0;
        bus.req_addr = '0;
    endtask

    task automatic run_one(input int src, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [N-1:0] hit, input logic [N-1:0] dirty,
                           input logic [N-1:0] noop_req, input int lat_mem,
                           input logic [1:0] fill, input int lat_exp,
                           input bit do_wb, input bit do_rd);
        int target;
        @(posedge clk);
        #1;
        mem_lat       = lat_mem;
        bus.snp_hit   = hit;
        bus.snp_dirty = dirty;
        snp_q.push_back('{src, op, addr});
        if (do_wb) mem_q.push_back('{1'b1, addr});
        if (do_rd) mem_q.push_back('{1'b0, addr});
        done_q.push_back('{src, fill, lat_exp});
        target = done_cnt + 1;
        bus.req           = noop_req | N'(1 << src);
        bus.req_op[src]   = op;
        bus.req_addr[src] = addr;
        t0 = cyc;
        wait_done(target);
        drop_requests();
    endtask

    initial begin
        int n;
        int target;
        drop_requests();
        bus.snp_hit   = '0;
        bus.snp_dirty = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // src op addr hit dirty noop_req memlat fill lat wb rd
        run_one(0, OP_BUSRD,   32'h1000, 2'b00, 2'b00, 2'b00, 2, MESI_E, 5, 0, 1);
        run_one(0, OP_BUSRD,   32'h1040, 2'b01, 2'b01, 2'b10, 1, MESI_E, 4, 0, 1);
        run_one(1, OP_BUSRD,   32'h1000, 2'b01, 2'b00, 2'b00, 0, MESI_S, 3, 0, 1);
        run_one(1, OP_BUSRDX,  32'h1000, 2'b01, 2'b01, 2'b00, 0, MESI_M, 4, 1, 1);
        run_one(1, OP_BUSUPGR, 32'h2000, 2'b01, 2'b01, 2'b00, 0, MESI_M, 3, 1, 0);

        // Both caches requesting continuously: grants alternate 0,1,0,1.
        @(posedge clk);
        #1;
        mem_lat       = 0;
        bus.snp_hit   = '0;
        bus.snp_dirty = '0;
        for (int k = 0; k < 4; k++) begin
            snp_q.push_back('{k % 2, OP_BUSRD, 32'h5000 + 32'(k % 2) * 32'h100});
            mem_q.push_back('{1'b0, 32'h5000 + 32'(k % 2) * 32'h100});
            done_q.push_back('{k % 2, MESI_E, -1});
        end
        target = done_cnt + 4;
        bus.req         = 2'b11;
        bus.req_op[0]   = OP_BUSRD;
        bus.req_op[1]   = OP_BUSRD;
        bus.req_addr[0] = 32'h5000;
        bus.req_addr[1] = 32'h5100;
        wait_done(target);
        drop_requests();

        run_one(0, OP_BUSUPGR, 32'h1000, 2'b10, 2'b00, 2'b00, 0, MESI_M, 2, 0, 0);

        // Reset while waiting in MEM_RD; pointer sits at 1 before the reset.
        @(posedge clk);
        #1;
        mem_lat       = 1000;
        bus.snp_hit   = '0;
        bus.snp_dirty = '0;
        snp_q.push_back('{0, OP_BUSRD, 32'h3000});
        mem_q.push_back('{1'b0, 32'h3000});
        bus.req         = 2'b01;
        bus.req_op[0]   = OP_BUSRD;
        bus.req_addr[0] = 32'h3000;
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_mem_rd", 64'(bus.mem_req), 64'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        drop_requests();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snp_q.push_back('{0, OP_BUSUPGR, 32'h4000});
        done_q.push_back('{0, MESI_M, 2});
        snp_q.push_back('{1, OP_BUSUPGR, 32'h4100});
        done_q.push_back('{1, MESI_M, -1});
        target = done_cnt + 2;
        bus.req         = 2'b11;
        bus.req_op[0]   = OP_BUSUPGR;
        bus.req_op[1]   = OP_BUSUPGR;
        bus.req_addr[0] = 32'h4000;
        bus.req_addr[1] = 32'h4100;
        t0 = cyc;
        wait_done(target);
        drop_requests();

        repeat (4) @(posedge clk);
        #1;
        check("snp_q_empty",  64'(snp_q.size()), 64'd0);
        check("mem_q_empty",  64'(mem_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
